// File: rtl/clock_time_ctrl_if.sv
// Button-pulse inputs and time/display outputs of the clock time controller.
// The controller takes the slave modport; the button/display side takes master.
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       sec_tick;

  modport slave (
    input  btn_mode, btn_inc,
    output hours, minutes, seconds, mode, blink, sec_tick
  );

  modport master (
    output btn_mode, btn_inc,
    input  hours, minutes, seconds, mode, blink, sec_tick
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// hh:mm:ss time keeping with a single-domain one-second prescaler,
// RUN/SET mode sequencing and a set-mode blink enable for the display.
module clock_time_ctrl #(
  parameter int CLK_HZ   = 12000000,
  parameter int BLINK_HZ = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  clock_time_ctrl_if.slave bus
);

  generate
    if (CLK_HZ < 4 || BLINK_HZ < 1 || (CLK_HZ % (2 * BLINK_HZ)) != 0) begin : g_param_err
      $error("clock_time_ctrl: CLK_HZ must be >= 4 and divisible by 2*BLINK_HZ");
    end
  endgenerate

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = $clog2(CLK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_t;

  mode_t         mode_r;
  logic [PW-1:0] prescale_r;
  logic [BW-1:0] blink_cnt_r;
  logic [4:0]    hours_r;
  logic [5:0]    minutes_r;
  logic [5:0]    seconds_r;
  logic          blink_r;
  logic          sec_tick_r;
  logic          tick_s;
  logic          inc_s;

  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] last);
    return (value == last) ? 6'd0 : value + 6'd1;
  endfunction

  // A mode pulse wins over a simultaneous increment pulse.
  assign tick_s = (mode_r == MODE_RUN) && (prescale_r == PRE_LAST);
  assign inc_s  = bus.btn_inc && !bus.btn_mode;

  // Prescaler, time counters, mode sequencing and blink generation.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= MODE_RUN;
      prescale_r  <= '0;
      blink_cnt_r <= '0;
      hours_r     <= 5'd0;
      minutes_r   <= 6'd0;
      seconds_r   <= 6'd0;
      blink_r     <= 1'b0;
      sec_tick_r  <= 1'b0;
    end else begin
      sec_tick_r <= tick_s;

      // Resuming from SET_SEC restarts a full second before the next tick.
      if (bus.btn_mode && mode_r == MODE_SET_SEC) begin
        prescale_r <= '0;
      end else if (prescale_r == PRE_LAST) begin
        prescale_r <= '0;
      end else begin
        prescale_r <= prescale_r + PW'(1);
      end

      if (tick_s) begin
        seconds_r <= wrap_inc(seconds_r, 6'd59);
        if (seconds_r == 6'd59) begin
          minutes_r <= wrap_inc(minutes_r, 6'd59);
          if (minutes_r == 6'd59) begin
            hours_r <= 5'(wrap_inc({1'b0, hours_r}, 6'd23));
          end else begin
            hours_r <= hours_r;
          end
        end else begin
          minutes_r <= minutes_r;
        end
      end else if (inc_s) begin
        case (mode_r)
          MODE_SET_HR:  hours_r   <= 5'(wrap_inc({1'b0, hours_r}, 6'd23));
          MODE_SET_MIN: minutes_r <= wrap_inc(minutes_r, 6'd59);
          MODE_SET_SEC: seconds_r <= 6'd0;
          default:      hours_r   <= hours_r;
        endcase
      end else begin
        seconds_r <= seconds_r;
      end

      if (bus.btn_mode) begin
        case (mode_r)
          MODE_RUN:     mode_r <= MODE_SET_HR;
          MODE_SET_HR:  mode_r <= MODE_SET_MIN;
          MODE_SET_MIN: mode_r <= MODE_SET_SEC;
          MODE_SET_SEC: mode_r <= MODE_RUN;
          default:      mode_r <= MODE_RUN;
        endcase
      end else begin
        mode_r <= mode_r;
      end

      // Every mode change restarts the blink phase from the dark half.
      if (bus.btn_mode || mode_r == MODE_RUN) begin
        blink_cnt_r <= '0;
        blink_r     <= 1'b0;
      end else if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end
  end

  assign bus.hours    = hours_r;
  assign bus.minutes  = minutes_r;
  assign bus.seconds  = seconds_r;
  assign bus.mode     = mode_r;
  assign bus.blink    = blink_r;
  assign bus.sec_tick = sec_tick_r;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Randomized and directed bench for clock_time_ctrl against a seconds-of-day
// reference model (CLK_HZ=10, BLINK_HZ=1).
module tb_clock_time_ctrl;
  localparam int CLK = 10;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clock_time_ctrl_if bus ();

  clock_time_ctrl #(.CLK_HZ(CLK), .BLINK_HZ(1)) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time as seconds since midnight, edges since the last
  // prescaler anchor, and edges spent in the current set mode.
  int t_sod, m_mode, m_edges, m_set_edges;
  bit m_tick;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t_sod = 0; m_mode = 0; m_edges = 0; m_set_edges = 0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit bm, input bit bi);
    int h, mi, s;
    m_edges++;
    m_tick = (m_mode == 0) && (m_edges % CLK == 0);
    h = t_sod / 3600; mi = (t_sod / 60) % 60; s = t_sod % 60;
    if (m_tick) begin
      t_sod = (t_sod + 1) % 86400;
    end else if (bi && !bm) begin
      if (m_mode == 1) h = (h + 1) % 24;
      else if (m_mode == 2) mi = (mi + 1) % 60;
      else if (m_mode == 3) s = 0;
      t_sod = h * 3600 + mi * 60 + s;
    end
    if (bm) begin
      if (m_mode == 3) m_edges = 0;
      m_mode = (m_mode + 1) % 4;
      m_set_edges = 0;
    end else if (m_mode != 0) begin
      m_set_edges++;
    end else begin
      m_set_edges = 0;
    end
  endtask

  task automatic check_all();
    check_eq("hours",    int'(bus.hours),    t_sod / 3600);
    check_eq("minutes",  int'(bus.minutes),  (t_sod / 60) % 60);
    check_eq("seconds",  int'(bus.seconds),  t_sod % 60);
    check_eq("mode",     int'(bus.mode),     m_mode);
    check_eq("blink",    int'(bus.blink),    int'((m_mode != 0) && ((m_set_edges / HALF) % 2 == 1)));
    check_eq("sec_tick", int'(bus.sec_tick), int'(m_tick));
  endtask

  task automatic cycle(input bit bm, input bit bi);
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    @(posedge clk);
    model_step(bm, bi);
    #1;
    check_all();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Count: ticks on edges 10, 20, 30.
    for (int e = 1; e <= 30; e++) begin
      cycle(1'b0, 1'b0);
      check_eq("count_tick", int'(bus.sec_tick), int'(e % 10 == 0));
    end
    check_eq("count_sec", int'(bus.seconds), 3);

    // Rollover: reach xx:xx:59, set 23:59, resume, wrap 10 edges later.
    do_reset();
    idle(590);
    check_eq("pre_roll_sec", int'(bus.seconds), 59);
    cycle(1'b1, 1'b0); incs(23);
    cycle(1'b1, 1'b0); incs(59);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    idle(9);
    check_eq("roll_early_sec", int'(bus.seconds), 59);
    cycle(1'b0, 1'b0);
    check_eq("roll_hours", int'(bus.hours), 0);
    check_eq("roll_tick", int'(bus.sec_tick), 1);
    cycle(1'b0, 1'b0);
    check_eq("roll_tick_once", int'(bus.sec_tick), 0);

    // Field wrap and conflicting buttons.
    do_reset();
    cycle(1'b1, 1'b0); incs(25);
    check_eq("wrap_hours", int'(bus.hours), 1);
    cycle(1'b1, 1'b0); incs(61);
    check_eq("wrap_minutes", int'(bus.minutes), 1);
    incs(4);
    cycle(1'b1, 1'b1);
    check_eq("conflict_mode", int'(bus.mode), 3);
    check_eq("conflict_minutes", int'(bus.minutes), 5);

    // Blink phases, mid-high mode change, and quiet resume.
    do_reset();
    cycle(1'b1, 1'b0);
    idle(7);
    check_eq("blink_high", int'(bus.blink), 1);
    cycle(1'b1, 1'b0);
    check_eq("blink_restart", int'(bus.blink), 0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    idle(9);

    // Asynchronous reset at 12:34:56 with the prescaler at 7.
    do_reset();
    cycle(1'b1, 1'b0); incs(12);
    cycle(1'b1, 1'b0); incs(34);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    idle(567);
    check_eq("pre_reset_sec", int'(bus.seconds), 56);
    do_reset();
    check_eq("reset_hours", int'(bus.hours), 0);
    idle(10);
    check_eq("post_reset_tick", int'(bus.sec_tick), 1);

    // Random button traffic.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
